// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 inverse key scheduler.
//   NR          : number of AES-128 rounds
//   state_t     : scheduler FSM encoding (IDLE / FWD / REV)
//   rcon()      : round-constant table, index 1..10 (0 and 11..15 return 0)
//   get_word()  : extract word 0..3 of a 128-bit key (word0 in [127:96])
//   rot_word()  : AES RotWord, cyclic left rotation by one byte
package aes_pkg;

   localparam int NR = 10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FWD  = 2'b01,
      REV  = 2'b10
   } state_t;

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1B;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   // Word 0 is the most significant word of the key.
   function automatic int word_msb(input int idx);
      return 127 - 32 * idx;
   endfunction

   function automatic logic [31:0] get_word(input logic [127:0] key, input int idx);
      return key[word_msb(idx) -: 32];
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Round-key handshake bundle between the scheduler and its consumer.
//   start/key_in/key_is_last : load request from the key register
//   busy                     : scheduler not idle
//   rk_valid/rk_ready        : round-key transfer handshake
//   rk_out/rk_round          : current round key and its round index
//   done                     : one-cycle pulse after the round-0 transfer
// master = consumer/controller side, slave = scheduler side.
interface aes_inv_key_sched_if;
   logic         start;
   logic [127:0] key_in;
   logic         key_is_last;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_out;
   logic [3:0]   rk_round;
   logic         done;

   modport master (
      output start, key_in, key_is_last, rk_ready,
      input  busy, rk_valid, rk_out, rk_round, done
   );

   modport slave (
      input  start, key_in, key_is_last, rk_ready,
      output busy, rk_valid, rk_out, rk_round, done
   );
endinterface

// File: rtl/Byte_Substitution.sv
// AES forward S-box, purely combinational.
//   i_byte : input byte
//   o_byte : SubBytes(i_byte)
module Byte_Substitution (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   // Entry 0 sits in the top byte, so entry i lives at bit 8*(255-i) = {~i, 3'b000}.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign o_byte = SBOX[{~i_byte, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule, forward or inverse (combinational).
//   i_key  : current round key, word0 in [127:96]
//   i_dir  : 0 = forward (round r -> r+1), 1 = inverse (round r -> r-1)
//   i_rcon : round constant for the step
//   o_key  : next round key
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] i_key,
   input  logic         i_dir,
   input  logic [7:0]   i_rcon,
   output logic [127:0] o_key
);
   logic [31:0] w_w0, w_w1, w_w2, w_w3;
   logic [31:0] w_sb_in, w_sub, w_t;
   logic [31:0] w_f0, w_f1, w_f2, w_f3;
   logic [31:0] w_p0, w_p1, w_p2, w_p3;

   assign w_w0 = get_word(i_key, 0);
   assign w_w1 = get_word(i_key, 1);
   assign w_w2 = get_word(i_key, 2);
   assign w_w3 = get_word(i_key, 3);

   // Inverse direction rebuilds the previous w3 as w3^w2 before feeding the S-boxes.
   assign w_sb_in = i_dir ? rot_word(w_w3 ^ w_w2) : rot_word(w_w3);

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      Byte_Substitution u_sbox (
         .i_byte (w_sb_in[8*g +: 8]),
         .o_byte (w_sub[8*g +: 8])
      );
   end

   assign w_t = w_sub ^ {i_rcon, 24'h000000};

   assign w_f0 = w_w0 ^ w_t;
   assign w_f1 = w_w1 ^ w_f0;
   assign w_f2 = w_w2 ^ w_f1;
   assign w_f3 = w_w3 ^ w_f2;

   assign w_p3 = w_w3 ^ w_w2;
   assign w_p2 = w_w2 ^ w_w1;
   assign w_p1 = w_w1 ^ w_w0;
   assign w_p0 = w_w0 ^ w_t;

   assign o_key = i_dir ? {w_p0, w_p1, w_p2, w_p3} : {w_f0, w_f1, w_f2, w_f3};
endmodule

// File: rtl/aes_inv_key_sched.sv
// Sequential AES-128 decryption key scheduler. Round keys are delivered in
// reverse order (10 down to 0), one per rk_valid/rk_ready transfer. A cipher
// key is first expanded forward for 10 cycles; a round-10 key skips that.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : handshake bundle (slave side), see aes_inv_key_sched_if
module aes_inv_key_sched
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   aes_inv_key_sched_if.slave    bus
);
   state_t        r_state, w_state_nxt;
   logic [127:0]  r_key, w_key_nxt, w_step;
   logic [3:0]    r_cnt, w_cnt_nxt, w_rcon_idx;
   logic          r_busy, r_valid, r_done;
   logic          w_busy_nxt, w_valid_nxt, w_done_nxt;
   logic          w_dir, w_xfer;

   assign w_xfer     = (r_state == REV) && bus.rk_ready;
   assign w_dir      = (r_state == REV);
   // Forward step from round cnt produces round cnt+1; inverse step from round cnt uses rcon[cnt].
   assign w_rcon_idx = (r_state == FWD) ? (r_cnt + 4'd1) : r_cnt;

   aes_key_step u_step (
      .i_key  (r_key),
      .i_dir  (w_dir),
      .i_rcon (rcon(w_rcon_idx)),
      .o_key  (w_step)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (bus.start) w_state_nxt = bus.key_is_last ? REV : FWD;
            else           w_state_nxt = IDLE;
         end
         FWD: begin
            if (r_cnt == 4'(NR - 1)) w_state_nxt = REV;
            else                     w_state_nxt = FWD;
         end
         REV: begin
            if (w_xfer && (r_cnt == 4'd0)) w_state_nxt = IDLE;
            else                           w_state_nxt = REV;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Key register and round counter next values
   always_comb begin
      w_key_nxt = r_key;
      w_cnt_nxt = r_cnt;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_key_nxt = bus.key_in;
               w_cnt_nxt = bus.key_is_last ? 4'(NR) : 4'd0;
            end else begin
               w_key_nxt = r_key;
               w_cnt_nxt = r_cnt;
            end
         end
         FWD: begin
            w_key_nxt = w_step;
            w_cnt_nxt = r_cnt + 4'd1;
         end
         REV: begin
            // Round 0 is the last key: it stays in place once transferred.
            if (w_xfer && (r_cnt != 4'd0)) begin
               w_key_nxt = w_step;
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_key_nxt = r_key;
               w_cnt_nxt = r_cnt;
            end
         end
         default: begin
            w_key_nxt = r_key;
            w_cnt_nxt = r_cnt;
         end
      endcase
   end

   // Output next values, registered below
   always_comb begin
      w_busy_nxt  = (w_state_nxt != IDLE);
      w_valid_nxt = (w_state_nxt == REV);
      w_done_nxt  = 1'b0;
      case (r_state)
         REV: begin
            if (w_xfer && (r_cnt == 4'd0)) w_done_nxt = 1'b1;
            else                           w_done_nxt = 1'b0;
         end
         default: w_done_nxt = 1'b0;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key   <= 128'd0;
         r_cnt   <= 4'd0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_key   <= w_key_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= w_busy_nxt;
         r_valid <= w_valid_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign bus.busy     = r_busy;
   assign bus.rk_valid = r_valid;
   assign bus.rk_out   = r_key;
   assign bus.rk_round = r_cnt;
   assign bus.done     = r_done;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed, table-driven bench for aes_inv_key_sched using the FIPS-197
// example keys. Inputs are driven and outputs sampled on the falling edge.
module tb_aes_inv_key_sched;

   localparam logic [127:0] KEY1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   typedef struct {
      logic [127:0] key;
      logic         last;
      int           lat;
      bit           bp;
      int           poke_fwd;
      int           poke_rev;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   aes_inv_key_sched_if bus ();

   aes_inv_key_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_errors = 0;
   logic [127:0] exp_rk [0:10];
   logic [127:0] got_rk [0:10];
   logic [3:0]   got_rnd [0:10];
   int           n_xfer;
   vec_t         vecs [0:5];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"},  128'(bus.busy),     128'd0);
      chk({tag, "_valid"}, 128'(bus.rk_valid), 128'd0);
      chk({tag, "_rkout"}, bus.rk_out,         128'd0);
      chk({tag, "_round"}, 128'(bus.rk_round), 128'd0);
      chk({tag, "_done"},  128'(bus.done),     128'd0);
   endtask

   // Consume round keys until 11 transfers or a cycle budget; ends on the done cycle.
   task automatic stream(input bit bp, input int poke_rev);
      logic [127:0] hold_k;
      logic [3:0]   hold_r;
      bit           stalled;
      bit           rdy;
      int           cyc;
      n_xfer  = 0;
      stalled = 1'b0;
      cyc     = 0;
      hold_k  = 128'd0;
      hold_r  = 4'd0;
      for (int i = 0; i < 11; i++) begin
         got_rk[i]  = 128'd0;
         got_rnd[i] = 4'hF;
      end
      while (n_xfer < 11 && cyc < 400) begin
         if (stalled) begin
            chk("stall_key",   bus.rk_out,         hold_k);
            chk("stall_round", 128'(bus.rk_round), 128'(hold_r));
         end
         chk("no_early_done", 128'(bus.done), 128'd0);
         bus.start       = (cyc == poke_rev);
         bus.key_in      = KEY2;
         bus.key_is_last = 1'b1;
         rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.rk_ready = rdy;
         if (bus.rk_valid && rdy) begin
            got_rk[n_xfer]  = bus.rk_out;
            got_rnd[n_xfer] = bus.rk_round;
            n_xfer++;
            stalled = 1'b0;
         end else if (bus.rk_valid) begin
            stalled = 1'b1;
            hold_k  = bus.rk_out;
            hold_r  = bus.rk_round;
         end else begin
            stalled = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      bus.start    = 1'b0;
      bus.rk_ready = 1'b0;
      chk("xfer_count",      128'(n_xfer),       128'd11);
      chk("done_pulse",      128'(bus.done),     128'd1);
      chk("busy_done_cycle", 128'(bus.busy),     128'd0);
      chk("valid_done_cyc",  128'(bus.rk_valid), 128'd0);
   endtask

   task automatic check_key1_seq();
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("seq_round_%0d", i), 128'(got_rnd[i]), 128'(10 - i));
         chk($sformatf("seq_key_r%0d", 10 - i), got_rk[i], exp_rk[10 - i]);
      end
   endtask

   // Issue start, measure latency to rk_valid, then stream; ends on the done cycle.
   task automatic launch(input vec_t v);
      int lat;
      @(negedge clk);
      bus.key_in      = v.key;
      bus.key_is_last = v.last;
      bus.start       = 1'b1;
      @(negedge clk);
      bus.start       = 1'b0;
      bus.key_in      = ~v.key;
      bus.key_is_last = ~v.last;
      lat = 1;
      while (!bus.rk_valid && lat < 40) begin
         chk("busy_fwd", 128'(bus.busy), 128'd1);
         bus.start = (lat == v.poke_fwd);
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      chk("latency", 128'(lat), 128'(v.lat));
      stream(v.bp, v.poke_rev);
   endtask

   task automatic run_full(input vec_t v);
      launch(v);
      check_key1_seq();
      @(negedge clk);
      chk("done_one_cycle", 128'(bus.done), 128'd0);
   endtask

   initial begin
      exp_rk[0]  = KEY1;
      exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      exp_rk[10] = KEY1_R10;

      vecs[0] = '{KEY1,     1'b0, 11, 1'b0, -1, -1};
      vecs[1] = '{KEY1_R10, 1'b1,  1, 1'b0, -1, -1};
      vecs[2] = '{KEY1,     1'b0, 11, 1'b1, -1, -1};
      vecs[3] = '{KEY1_R10, 1'b1,  1, 1'b1, -1, -1};
      vecs[4] = '{KEY1,     1'b0, 11, 1'b0,  4,  3};
      vecs[5] = '{KEY1_R10, 1'b1,  1, 1'b1, -1,  5};

      bus.start       = 1'b0;
      bus.key_in      = 128'd0;
      bus.key_is_last = 1'b0;
      bus.rk_ready    = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      #2 check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_full(vecs[i]);

      // Reset during FWD cycle 5
      @(negedge clk);
      bus.key_in = KEY1; bus.key_is_last = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("fwd_busy_pre_rst", 128'(bus.busy), 128'd1);
      rst_n = 1'b0;
      #1 check_zero("rst_fwd");
      repeat (3) begin
         @(negedge clk);
         chk("rst_fwd_no_done", 128'(bus.done), 128'd0);
      end
      rst_n = 1'b1;
      run_full(vecs[0]);

      // Reset during REV at round 6
      @(negedge clk);
      bus.key_in = KEY1_R10; bus.key_is_last = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.rk_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (!(bus.rk_valid && bus.rk_round == 4'd6)) @(negedge clk);
      end
      chk("rev_round_pre_rst", 128'(bus.rk_round), 128'd6);
      chk("rev_key_pre_rst",   bus.rk_out,         exp_rk[6]);
      rst_n = 1'b0;
      #1 check_zero("rst_rev");
      repeat (3) begin
         @(negedge clk);
         chk("rst_rev_no_done", 128'(bus.done), 128'd0);
      end
      bus.rk_ready = 1'b0;
      rst_n = 1'b1;
      run_full(vecs[1]);

      // Back-to-back: new start accepted in the done cycle
      launch(vecs[1]);
      check_key1_seq();
      bus.key_in = KEY2; bus.key_is_last = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("b2b_busy", 128'(bus.busy), 128'd1);
      begin
         int lat;
         lat = 1;
         while (!bus.rk_valid && lat < 40) begin
            @(negedge clk);
            lat++;
         end
         chk("b2b_latency", 128'(lat), 128'd11);
      end
      stream(1'b0, -1);
      chk("b2b_first_round", 128'(got_rnd[0]),  128'd10);
      chk("b2b_r10_key",     got_rk[0],         KEY2_R10);
      chk("b2b_last_round",  128'(got_rnd[10]), 128'd0);
      chk("b2b_r0_key",      got_rk[10],        KEY2);
      @(negedge clk);
      chk("b2b_done_clear", 128'(bus.done), 128'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
